// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer for ECP5 EHXPLLL: pulses PLL RST, qualifies LOCK, gates the PLL-domain reset.
// Optional WAIT_LOCK timeout/retry is built only when PLL_LOCK_RETRY_EN is defined.
`timescale 1ns/1ps

module pll_lock_sequencer #(
  parameter int RST_CYCLES     = 16,
  parameter int LOCK_CYCLES    = 1024,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CNT_W          = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lock_in,
  output logic       pll_rst,
  output logic       rst_out,
  output logic       ready,
  output logic [7:0] retry_count,
  output logic [7:0] loss_count
);

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);

  // Reject configurations whose terminal counts do not fit the shared counter.
  if (RST_CYCLES < 1 || LOCK_CYCLES < 1 || TIMEOUT_CYCLES < 2 ||
      ((RST_CYCLES - 1) >> CNT_W) != 0 ||
      ((LOCK_CYCLES - 1) >> CNT_W) != 0 ||
      ((TIMEOUT_CYCLES - 1) >> CNT_W) != 0) begin : g_param_check
    $error("pll_lock_sequencer: invalid cycle parameters for CNT_W");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sync_q, sync_d;
  logic [7:0]       loss_q, loss_d;
  logic             lock_s;

  // Two-flop synchronizer; only the second stage is seen by the FSM.
  always_comb begin
    sync_d = {sync_q[0], lock_in};
  end

  assign lock_s = sync_q[1];

`ifdef PLL_LOCK_RETRY_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [7:0] retry_q, retry_d;
`endif

  always_comb begin
    state_d = state_q;
    loss_d  = loss_q;
`ifdef PLL_LOCK_RETRY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
        end
`ifdef PLL_LOCK_RETRY_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_PLL_RST;
          if (retry_q != 8'hFF) begin
            retry_d = retry_q + 8'd1;
          end
        end
`endif
      end
      ST_STABLE: begin
        // A dropout during qualification is a glitch: restart without counting a loss.
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          if (loss_q != 8'hFF) begin
            loss_d = loss_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = ST_PLL_RST;
      end
    endcase
  end

  // Shared dwell counter; it saturates so long waits in WAIT_LOCK or RUN never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_PLL_RST;
      cnt_q   <= '0;
      sync_q  <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      loss_q  <= loss_d;
    end
  end

`ifdef PLL_LOCK_RETRY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end

  assign retry_count = retry_q;
`else
  assign retry_count = 8'd0;
`endif

  assign pll_rst    = (state_q == ST_PLL_RST);
  assign rst_out    = (state_q != ST_RUN);
  assign ready      = (state_q == ST_RUN);
  assign loss_count = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed self-checking bench for pll_lock_sequencer (RST=4, LOCK=8, TIMEOUT=32, CNT_W=6).
// Retry scenarios follow PLL_LOCK_RETRY_EN; the no-retry scenario runs when it is undefined.
`timescale 1ns/1ps

module tb_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lock_in = 1'b0;
  logic       pll_rst;
  logic       rst_out;
  logic       ready;
  logic [7:0] retry_count;
  logic [7:0] loss_count;

  int n_cmp = 0;
  int n_bad = 0;

  pll_lock_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_CYCLES   (8),
    .TIMEOUT_CYCLES(32),
    .CNT_W         (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lock_in    (lock_in),
    .pll_rst    (pll_rst),
    .rst_out    (rst_out),
    .ready      (ready),
    .retry_count(retry_count),
    .loss_count (loss_count)
  );

  always #5 clk = ~clk;

  // Advance k rising edges, settling 1 ns past each so sampling is away from the edge.
  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       pick = pll_rst;
      1:       pick = rst_out;
      default: pick = ready;
    endcase
  endfunction

  // Count edges until the selected output equals val, giving up after max_edges.
  task automatic wait_for(input int sel, input logic val, input int max_edges, output int n);
    n = 0;
    while (pick(sel) !== val && n < max_edges) begin
      step(1);
      n++;
    end
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1;
    lock_in = 1'b1;
    step(3);
    n_cmp++; if (pll_rst !== 1'b1) begin n_bad++; $display("FAIL reset_pll_rst: got %b want 1", pll_rst); end
    n_cmp++; if (rst_out !== 1'b1) begin n_bad++; $display("FAIL reset_rst_out: got %b want 1", rst_out); end
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_cmp++; if (retry_count !== 8'd0) begin n_bad++; $display("FAIL reset_retry: got %0d want 0", retry_count); end
    n_cmp++; if (loss_count !== 8'd0) begin n_bad++; $display("FAIL reset_loss: got %0d want 0", loss_count); end
    rst = 1'b0;
    wait_for(0, 1'b0, 50, n);
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL powerup_pll_rst_width: got %0d want 4", n); end
    wait_for(2, 1'b1, 50, n);
    n_cmp++; if (n !== 9) begin n_bad++; $display("FAIL powerup_ready_delay: got %0d want 9", n); end
    n_cmp++; if (rst_out !== 1'b0) begin n_bad++; $display("FAIL powerup_rst_out: got %b want 0", rst_out); end
    n_cmp++; if (loss_count !== 8'd0 || retry_count !== 8'd0) begin
      n_bad++; $display("FAIL powerup_counts: got %0d/%0d want 0/0", retry_count, loss_count);
    end
    $display("test_reset done");
  endtask

  // Glitch one cycle after 5 cycles of qualification; RUN lands 12 edges later instead of 3.
  task automatic test_glitch;
    int pr_hits;
    int early;
    pr_hits = 0;
    early = 0;
    rst = 1'b1;
    lock_in = 1'b1;
    step(2);
    rst = 1'b0;
    step(10);
    lock_in = 1'b0;
    step(1);
    if (pll_rst) pr_hits++;
    if (ready) early++;
    lock_in = 1'b1;
    for (int i = 2; i <= 12; i++) begin
      step(1);
      if (pll_rst) pr_hits++;
      if (i < 12 && ready) early++;
    end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL glitch_ready_at_12: got %b want 1", ready); end
    n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL glitch_early_ready: got %0d cycles want 0", early); end
    n_cmp++; if (pr_hits !== 0) begin n_bad++; $display("FAIL glitch_pll_rst: got %0d cycles want 0", pr_hits); end
    n_cmp++; if (loss_count !== 8'd0) begin n_bad++; $display("FAIL glitch_loss: got %0d want 0", loss_count); end
    $display("test_glitch done");
  endtask

  task automatic test_lock_loss;
    int n;
    lock_in = 1'b0;
    step(1);
    n_cmp++; if (rst_out !== 1'b0) begin n_bad++; $display("FAIL loss_edge1_rst_out: got %b want 0", rst_out); end
    step(1);
    n_cmp++; if (rst_out !== 1'b0) begin n_bad++; $display("FAIL loss_edge2_rst_out: got %b want 0", rst_out); end
    step(1);
    n_cmp++; if (rst_out !== 1'b1) begin n_bad++; $display("FAIL loss_edge3_rst_out: got %b want 1", rst_out); end
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL loss_edge3_ready: got %b want 0", ready); end
    n_cmp++; if (loss_count !== 8'd1) begin n_bad++; $display("FAIL loss_count: got %0d want 1", loss_count); end
    step(7);
    lock_in = 1'b1;
    wait_for(2, 1'b1, 50, n);
    n_cmp++; if (n !== 11) begin n_bad++; $display("FAIL loss_relock_delay: got %0d want 11", n); end
    n_cmp++; if (loss_count !== 8'd1) begin n_bad++; $display("FAIL loss_count_hold: got %0d want 1", loss_count); end
    n_cmp++; if (pll_rst !== 1'b0) begin n_bad++; $display("FAIL loss_pll_rst: got %b want 0", pll_rst); end
    $display("test_lock_loss done");
  endtask

  task automatic test_loss_saturation;
    int n;
    int seq_bad;
    int wraps;
    logic [7:0] prev;
    seq_bad = 0;
    wraps = 0;
    prev = loss_count;
    for (int i = 0; i < 260; i++) begin
      lock_in = 1'b0;
      wait_for(2, 1'b0, 10, n);
      if (n != 3) seq_bad++;
      lock_in = 1'b1;
      wait_for(2, 1'b1, 30, n);
      if (n != 11) seq_bad++;
      if (loss_count < prev) wraps++;
      prev = loss_count;
    end
    n_cmp++; if (seq_bad !== 0) begin n_bad++; $display("FAIL loss_sat_timing: got %0d bad phases want 0", seq_bad); end
    n_cmp++; if (wraps !== 0) begin n_bad++; $display("FAIL loss_sat_wrap: got %0d wraps want 0", wraps); end
    n_cmp++; if (loss_count !== 8'd255) begin n_bad++; $display("FAIL loss_sat_value: got %0d want 255", loss_count); end
    $display("test_loss_saturation done");
  endtask

  task automatic test_reset_mid_run;
    int n;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL midrun_pre_ready: got %b want 1", ready); end
    rst = 1'b1;
    step(1);
    n_cmp++; if (pll_rst !== 1'b1 || rst_out !== 1'b1 || ready !== 1'b0) begin
      n_bad++; $display("FAIL midrun_outputs: got %b%b%b want 110", pll_rst, rst_out, ready);
    end
    n_cmp++; if (loss_count !== 8'd0 || retry_count !== 8'd0) begin
      n_bad++; $display("FAIL midrun_counts: got %0d/%0d want 0/0", retry_count, loss_count);
    end
    rst = 1'b0;
    wait_for(0, 1'b0, 50, n);
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL midrun_pll_rst_width: got %0d want 4", n); end
    wait_for(2, 1'b1, 50, n);
    n_cmp++; if (n !== 9) begin n_bad++; $display("FAIL midrun_ready_delay: got %0d want 9", n); end
    $display("test_reset_mid_run done");
  endtask

`ifdef PLL_LOCK_RETRY_EN
  task automatic test_retry;
    int n;
    rst = 1'b1;
    lock_in = 1'b0;
    step(2);
    rst = 1'b0;
    wait_for(0, 1'b0, 50, n);
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL retry_first_width: got %0d want 4", n); end
    for (int k = 1; k <= 3; k++) begin
      wait_for(0, 1'b1, 100, n);
      n_cmp++; if (n !== 32) begin n_bad++; $display("FAIL retry_timeout_%0d: got %0d want 32", k, n); end
      n_cmp++; if (retry_count !== 8'(k)) begin n_bad++; $display("FAIL retry_count_%0d: got %0d want %0d", k, retry_count, k); end
      wait_for(0, 1'b0, 50, n);
      n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL retry_width_%0d: got %0d want 4", k, n); end
    end
    lock_in = 1'b1;
    wait_for(2, 1'b1, 50, n);
    n_cmp++; if (n !== 11) begin n_bad++; $display("FAIL retry_lock_delay: got %0d want 11", n); end
    n_cmp++; if (retry_count !== 8'd3) begin n_bad++; $display("FAIL retry_count_hold: got %0d want 3", retry_count); end
    $display("test_retry done");
  endtask

  task automatic test_retry_saturation;
    int wraps;
    logic [7:0] prev;
    wraps = 0;
    rst = 1'b1;
    lock_in = 1'b0;
    step(2);
    rst = 1'b0;
    prev = retry_count;
    for (int i = 0; i < 260 * 36 + 10; i++) begin
      step(1);
      if (retry_count < prev) wraps++;
      prev = retry_count;
    end
    n_cmp++; if (wraps !== 0) begin n_bad++; $display("FAIL retry_sat_wrap: got %0d wraps want 0", wraps); end
    n_cmp++; if (retry_count !== 8'd255) begin n_bad++; $display("FAIL retry_sat_value: got %0d want 255", retry_count); end
    $display("test_retry_saturation done");
  endtask
`else
  task automatic test_no_retry;
    int n;
    int pr_hits;
    pr_hits = 0;
    rst = 1'b1;
    lock_in = 1'b0;
    step(2);
    rst = 1'b0;
    wait_for(0, 1'b0, 50, n);
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL noretry_first_width: got %0d want 4", n); end
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (pll_rst) pr_hits++;
    end
    n_cmp++; if (pr_hits !== 0) begin n_bad++; $display("FAIL noretry_pll_rst: got %0d cycles want 0", pr_hits); end
    n_cmp++; if (retry_count !== 8'd0) begin n_bad++; $display("FAIL noretry_count: got %0d want 0", retry_count); end
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL noretry_ready: got %b want 0", ready); end
    $display("test_no_retry done");
  endtask
`endif

  initial begin
    test_reset();
    test_glitch();
    test_lock_loss();
    test_loss_saturation();
    test_reset_mid_run();
`ifdef PLL_LOCK_RETRY_EN
    test_retry();
    test_retry_saturation();
`else
    test_no_retry();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
